// File: rtl/irq_pkg.sv
// irq_pkg: shared definitions for the machine-mode interrupt sequencer.
// Holds the CSR addresses, interrupt cause codes, bit positions within
// mstatus/mie/mip, the sequencer state type and the trap vector helper.
package irq_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MTI_BIT          = 7;
  localparam int MEI_BIT          = 11;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HANDLER
  } irq_state_e;

  // Trap target: the aligned mtvec base, offset by 4*code in vectored mode.
  function automatic logic [31:0] trap_vector(input logic [31:0] mtvec,
                                              input logic [3:0]  code);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (mtvec[1:0] == 2'b01) begin
      base = base + {26'd0, code, 2'b00};
    end
    return base;
  endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// irq_edge_latch: rising-edge detector with a sticky pending bit.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   line       : raw level interrupt line
//   clr        : clear request for the pending bit (a set in the same cycle wins)
//   pending    : sticky pending flag
module irq_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic line,
  input  logic clr,
  output logic pending
);

  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic seen_q, seen_d;
  logic pend_q, pend_d;

  // On the first edge after reset the previous-sample register is loaded with
  // the live line, so a line already high when reset drops is not an edge.
  always_comb begin
    sync_d = line;
    prev_d = seen_q ? sync_q : line;
    seen_d = 1'b1;
    pend_d = (pend_q & ~clr) | (sync_q & ~prev_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      seen_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      seen_q <= seen_d;
      pend_q <= pend_d;
    end
  end

  assign pending = pend_q;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: machine-mode interrupt and trap sequencer for the single-cycle
// datapath. Owns mstatus.MIE/MPIE, mie, mip, mtvec, mepc and mcause, picks the
// instruction boundary on which an interrupt is taken and supplies the PC
// redirect for trap entry and mret.
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   MTI, EI             : timer / external interrupt lines (level)
//   commit, pc_next     : instruction retires this cycle, its fall-through PC
//   mret                : committing instruction is mret
//   csr_we, csr_addr,
//   csr_wdata           : CSR write port (data already resolved)
//   csr_rdata           : combinational CSR read, unmapped reads 0
//   redirect,
//   redirect_pc         : PC override for this edge (trap vector or mepc)
//   trap_take           : an interrupt is taken this cycle
module irq_ctrl
  import irq_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MTI,
  input  logic        EI,
  input  logic        commit,
  input  logic [31:0] pc_next,
  input  logic        mret,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        trap_take
);

  irq_state_e  state_q, state_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic        mtie_q, mtie_d;
  logic        meie_q, meie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;

  logic        mtip, meip;
  logic        mti_en, mei_en, eligible, take, mret_fire, win_mei;
  logic [3:0]  win_code;

  irq_edge_latch u_mti_latch (
    .clk     (clk),
    .reset   (reset),
    .line    (MTI),
    .clr     (take & ~win_mei),
    .pending (mtip)
  );

  irq_edge_latch u_mei_latch (
    .clk     (clk),
    .reset   (reset),
    .line    (EI),
    .clr     (take & win_mei),
    .pending (meip)
  );

  // Eligibility and priority; the handler state blocks all traps (no nesting).
  assign mti_en    = mtip & mtie_q;
  assign mei_en    = meip & meie_q;
  assign eligible  = (mti_en | mei_en) & mie_q & (state_q != HANDLER);
  assign win_mei   = mei_en;
  assign win_code  = win_mei ? CAUSE_MEI : CAUSE_MTI;
  assign mret_fire = commit & mret;
  assign take      = (state_q == ARMED) & commit & ~mret & eligible;

  // CSR next-state: software writes first, then trap entry / mret override
  // mstatus, mepc and mcause. mie and mtvec writes are never overridden.
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtie_d   = mtie_q;
    meie_d   = meie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (csr_we) begin
      unique case (csr_addr)
        CSR_MSTATUS: begin
          mie_d  = csr_wdata[MSTATUS_MIE_BIT];
          mpie_d = csr_wdata[MSTATUS_MPIE_BIT];
        end
        CSR_MIE: begin
          mtie_d = csr_wdata[MTI_BIT];
          meie_d = csr_wdata[MEI_BIT];
        end
        CSR_MTVEC:  mtvec_d  = (csr_wdata[1:0] == 2'b01) ? csr_wdata
                                                         : {csr_wdata[31:2], 2'b00};
        CSR_MEPC:   mepc_d   = csr_wdata & 32'hFFFF_FFFC;
        CSR_MCAUSE: mcause_d = csr_wdata;
        default: ;
      endcase
    end
    if (take) begin
      mepc_d   = pc_next & 32'hFFFF_FFFC;
      mcause_d = {1'b1, 27'd0, win_code};
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_fire) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  // Sequencer: wait for an eligible cause, take it on the next non-mret
  // commit, and stay in the handler until its mret.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (eligible) state_d = ARMED;
      ARMED: begin
        if (take)           state_d = HANDLER;
        else if (!eligible) state_d = IDLE;
      end
      HANDLER: if (mret_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtie_q   <= 1'b0;
      meie_q   <= 1'b0;
      mtvec_q  <= RESET_MTVEC;
      mepc_q   <= 32'd0;
      mcause_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtie_q   <= mtie_d;
      meie_q   <= meie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

  // Outputs are held quiet while reset is asserted.
  always_comb begin
    csr_rdata = 32'd0;
    if (!reset) begin
      unique case (csr_addr)
        CSR_MSTATUS: begin
          csr_rdata[MSTATUS_MIE_BIT]  = mie_q;
          csr_rdata[MSTATUS_MPIE_BIT] = mpie_q;
        end
        CSR_MIE: begin
          csr_rdata[MTI_BIT] = mtie_q;
          csr_rdata[MEI_BIT] = meie_q;
        end
        CSR_MTVEC:  csr_rdata = mtvec_q;
        CSR_MEPC:   csr_rdata = mepc_q;
        CSR_MCAUSE: csr_rdata = mcause_q;
        CSR_MIP: begin
          csr_rdata[MTI_BIT] = mtip;
          csr_rdata[MEI_BIT] = meip;
        end
        default: ;
      endcase
    end
  end

  assign trap_take   = take & ~reset;
  assign redirect    = (take | mret_fire) & ~reset;
  assign redirect_pc = take ? trap_vector(mtvec_q, win_code) : mepc_q;

endmodule
